// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key encoder slice.
//   KEY_NUM        number of active-low key/select lines
//   CODE_W         width of the encoded key index
//   KEYS_RELEASED  line pattern with no key pressed
//   deb_state_e    debounce FSM state encoding
//   prio_code()    index of the lowest-numbered pressed key
//   multi_press()  true when more than one key is pressed
package key_pkg;

   localparam int KEY_NUM = 8;
   localparam int CODE_W  = 3;
   localparam logic [KEY_NUM-1:0] KEYS_RELEASED = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_UPDATE = 2'd2
   } deb_state_e;

   // Scan from the top down so the lowest pressed index is written last and wins.
   function automatic logic [CODE_W-1:0] prio_code(input logic [KEY_NUM-1:0] keys_n);
      logic [CODE_W-1:0] c;
      c = {CODE_W{1'b0}};
      for (int i = KEY_NUM - 1; i >= 0; i--) begin
         if (!keys_n[i]) begin
            c = CODE_W'(i);
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   // Clearing the lowest set bit of the pressed mask leaves something only if
   // at least two keys are down.
   function automatic logic multi_press(input logic [KEY_NUM-1:0] keys_n);
      logic [KEY_NUM-1:0] pressed;
      pressed = ~keys_n;
      return ((pressed & (pressed - KEY_NUM'(1))) != {KEY_NUM{1'b0}});
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce -- synchronises and debounces the raw key lines.
// Ports:
//   sys_clk     in   system clock
//   sys_rst     in   synchronous active-high reset
//   key_n       in   raw active-low key lines (asynchronous)
//   stable      out  last accepted (debounced) line pattern
//   stable_upd  out  one-cycle strobe, high in the cycle after stable is loaded
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [KEY_NUM-1:0] key_n,
   output logic [KEY_NUM-1:0] stable,
   output logic               stable_upd
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   logic [KEY_NUM-1:0] sync1_q, sync1_d;
   logic [KEY_NUM-1:0] sync_n_q, sync_n_d;
   logic [KEY_NUM-1:0] cand_q, cand_d;
   logic [KEY_NUM-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   deb_state_e         state_q, state_d;

   // Next-state logic: synchroniser shift, candidate tracking and stability count.
   always_comb begin
      sync1_d  = key_n;
      sync_n_d = sync1_q;
      state_d  = state_q;
      cand_d   = cand_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      case (state_q)
         // S_UPDATE lasts one cycle and then behaves exactly like S_IDLE.
         S_IDLE, S_UPDATE: begin
            if (sync_n_q != cand_q) begin
               cand_d  = sync_n_q;
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_COUNT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_COUNT: begin
            if (sync_n_q != cand_q) begin
               cand_d = sync_n_q;
               cnt_d  = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_MAX) begin
               // Counter stays at CNT_MAX here; it is cleared on the next load.
               stable_d = cand_q;
               state_d  = S_UPDATE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cand_d  = KEYS_RELEASED;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State registers with synchronous reset to the all-released pattern.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_q  <= KEYS_RELEASED;
         sync_n_q <= KEYS_RELEASED;
         cand_q   <= KEYS_RELEASED;
         stable_q <= KEYS_RELEASED;
         cnt_q    <= {CNT_W{1'b0}};
         state_q  <= S_IDLE;
      end else begin
         sync1_q  <= sync1_d;
         sync_n_q <= sync_n_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   assign stable     = stable_q;
   assign stable_upd = (state_q == S_UPDATE);

endmodule

// File: rtl/key_encoder.sv
// key_encoder -- debounced priority encoder for 8 active-low key lines.
// Ports:
//   sys_clk   in   system clock
//   sys_rst   in   synchronous active-high reset
//   key_n     in   raw active-low key lines (asynchronous)
//   code      out  index of the lowest pressed key in the accepted pattern
//   code_vld  out  one-cycle pulse for each new pressed pattern
//   key_any   out  high while the accepted pattern has a key pressed
//   multi     out  high while the accepted pattern has several keys pressed
module key_encoder
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic [KEY_NUM-1:0] key_n,
   output logic [CODE_W-1:0]  code,
   output logic               code_vld,
   output logic               key_any,
   output logic               multi
);

   logic [KEY_NUM-1:0] stable;
   logic               stable_upd;

   logic [CODE_W-1:0]  code_q, code_d;
   logic               code_vld_q, code_vld_d;
   logic               key_any_q, key_any_d;
   logic               multi_q, multi_d;
   logic [KEY_NUM-1:0] prev_q, prev_d;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_debounce (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key_n      (key_n),
      .stable     (stable),
      .stable_upd (stable_upd)
   );

   // Output update on each accepted pattern; prev_q remembers the last one so
   // a re-accepted identical pattern does not pulse again.
   always_comb begin
      code_d     = code_q;
      code_vld_d = 1'b0;
      key_any_d  = key_any_q;
      multi_d    = multi_q;
      prev_d     = prev_q;
      if (stable_upd) begin
         prev_d = stable;
         if (stable == KEYS_RELEASED) begin
            key_any_d = 1'b0;
            multi_d   = 1'b0;
         end else if (stable != prev_q) begin
            code_d     = prio_code(stable);
            multi_d    = multi_press(stable);
            key_any_d  = 1'b1;
            code_vld_d = 1'b1;
         end else begin
            code_vld_d = 1'b0;
         end
      end else begin
         prev_d = prev_q;
      end
   end

   // Output registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         code_q     <= {CODE_W{1'b0}};
         code_vld_q <= 1'b0;
         key_any_q  <= 1'b0;
         multi_q    <= 1'b0;
         prev_q     <= KEYS_RELEASED;
      end else begin
         code_q     <= code_d;
         code_vld_q <= code_vld_d;
         key_any_q  <= key_any_d;
         multi_q    <= multi_d;
         prev_q     <= prev_d;
      end
   end

   assign code     = code_q;
   assign code_vld = code_vld_q;
   assign key_any  = key_any_q;
   assign multi    = multi_q;

endmodule

// File: doc/key_encoder.md
Name: key_encoder

Overview:
- Inverse of the 3-to-8 active-low select decoder: takes 8 active-low one-hot-style key/select lines and produces the 3-bit index.
- Synchronises, debounces and priority-encodes the lines, then emits a one-cycle event pulse per new stable pressed pattern.
- Sits between board pushbuttons or select lines and downstream control logic.
- Round-trip property: decoder(key_encoder.code) == key_n for any single-key pattern.

Parameters:
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a pattern (20 ms at 50 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYC), debounce counter width; derived, not overridden.

Ports:
- sys_clk  input  1  system clock, single clock domain.
- sys_rst  input  1  synchronous, active-high reset.
- key_n  input  8  raw active-low key lines, asynchronous to sys_clk; bit i low = key i pressed.
- code  output  3  index of the lowest-numbered pressed key in the accepted pattern.
- code_vld  output  1  one-cycle pulse when code/multi update for a new pressed pattern.
- key_any  output  1  level; high while the accepted pattern has at least one key pressed.
- multi  output  1  level; high while the accepted pattern has more than one key pressed.

Behaviour:
- Reset is synchronous and active-high and sampled only on the sys_clk rising edge. Reset values:
  - synchroniser flops = 8'hFF, candidate = 8'hFF, stable = 8'hFF, counter = 0;
  - code = 3'd0, code_vld = 0, key_any = 0, multi = 0.
- Synchroniser: 2-flop chain on all 8 bits. The synchronised vector is sync_n.
- Debounce FSM, three states:
  - S_IDLE: stable == candidate and sync_n == candidate. If sync_n != candidate: load candidate <= sync_n, counter <= 0, go to S_COUNT.
  - S_COUNT:
    - If sync_n != candidate: reload candidate and clear counter (restart); stay in S_COUNT.
    - Else if counter == DEBOUNCE_CYC-1: stable <= candidate, go to S_UPDATE.
    - Else: counter + 1.
  - S_UPDATE, one cycle:
    - If stable != 8'hFF and stable differs from the previously accepted pattern: register code, multi and key_any = 1, and pulse code_vld.
    - If stable == 8'hFF: key_any <= 0, multi <= 0, code holds its last value, no pulse.
    - Return to S_IDLE, or to S_COUNT if sync_n already differs (handled by the same rule as S_IDLE).
- Latency: counting the first edge that samples the new key_n value as edge 0:
  - stable updates at edge DEBOUNCE_CYC+2;
  - code, code_vld and multi update at edge DEBOUNCE_CYC+3.
- Priority: the lowest index wins. For example, 8'b1110_0111 gives code = 3 and multi = 1.
- A glitch shorter than DEBOUNCE_CYC consecutive cycles never reaches stable. No pulse and no output change.
- Press-to-press change without an intervening release (for example, key 2 to key 6) produces a new pulse with the new code.
- A pattern returning to the same accepted value produces no pulse.
- Counter saturation: the counter never exceeds DEBOUNCE_CYC-1. No wrap.
- Reset asserted mid-debounce or during S_UPDATE: all state returns to reset values on that edge, and no pulse is emitted in that cycle.
  - After reset deassertion with keys still held, the held pattern is debounced afresh and produces one pulse.
- code_vld is never high in two consecutive cycles.

Decomposition:
- Shared package key_pkg:
  - KEY_NUM = 8, CODE_W = 3, KEYS_RELEASED = 8'hFF;
  - FSM state encoding S_IDLE / S_COUNT / S_UPDATE.
- Natural sub-module key_debounce:
  - contains the synchroniser, candidate register, counter and FSM;
  - outputs stable[7:0] and a one-cycle stable_upd strobe.
- key_encoder instantiates key_debounce and holds the priority encoder and the output registers.

Test Plan (all scenarios use DEBOUNCE_CYC = 4):
- Reset with key_n = 8'hFF held for 3 cycles -> code = 0, code_vld = 0, key_any = 0, multi = 0 throughout; no pulse for 20 cycles after release of reset.
- Single press: key_n = 8'b1101_1111, sampled at edge 0 and held -> exactly one code_vld pulse at edge 7, code = 5, key_any = 1, multi = 0. Feeding code into decoder returns 8'b1101_1111.
- Bounce: key_n toggles between 8'hFF and 8'b1111_1011 every 2 cycles for 30 cycles, then settles at 8'hFF -> no code_vld pulse, key_any stays 0.
- Multi-key and change without release:
  - 8'b1110_0111 held -> pulse, code = 3, multi = 1.
  - Then 8'b1011_1111 held -> second pulse, code = 6, multi = 0.
  - Then 8'hFF -> key_any = 0 and multi = 0 at edge 7 after the change, code stays 6, no pulse.
- Sweep all 8 single-key patterns with a release between each -> 8 pulses with code = 0..7 in order, each matching the decoder round-trip.
- Reset mid-operation: key 1 pressed, sys_rst asserted at counter = 2 for 1 cycle, key still held -> no pulse before reset; after reset, one pulse with code = 1 at edge 7 counted from the first post-reset sampling edge.
